// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes the instruction, selects/bypasses operands, registers src1/src2/func for the ALU.
// Latency: 1 cycle from an accepted valid_i to valid_o.
// Backpressure: ready_o = !valid_o || ready_i; outputs hold while valid_o && !ready_i; flush_i drops the held entry.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   valid_i / ready_o             upstream handshake (instr_i, pc_i, rs1/rs2_data_i)
//   ex_fwd_* / wb_fwd_*           EX/MEM and MEM/WB bypass sources (EX wins)
//   flush_i                       kill the registered instruction
//   ready_i / valid_o             downstream (ALU) handshake
//   src1_o, src2_o, func_o, rd_o, illegal_o   registered ALU operands and control
module alu_issue_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        ex_fwd_we_i,
    input  logic [4:0]  ex_fwd_rd_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic        wb_fwd_we_i,
    input  logic [4:0]  wb_fwd_rd_i,
    input  logic [31:0] wb_fwd_data_i,
    input  logic        flush_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [3:0]  func_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_XOR  = 4'h2;
    localparam logic [3:0] FN_OR   = 4'h3;
    localparam logic [3:0] FN_AND  = 4'h4;
    localparam logic [3:0] FN_SLTU = 4'h5;
    localparam logic [3:0] FN_SLT  = 4'h6;
    localparam logic [3:0] FN_SLL  = 4'h7;
    localparam logic [3:0] FN_SRL  = 4'h8;
    localparam logic [3:0] FN_SRA  = 4'h9;
    localparam logic [3:0] FN_EQ   = 4'hA;
    localparam logic [3:0] FN_NE   = 4'hB;
    localparam logic [3:0] FN_GEU  = 4'hC;
    localparam logic [3:0] FN_GE   = 4'hD;
    localparam logic [3:0] FN_LINK = 4'hE;
    localparam logic [3:0] FN_PASS = 4'hF;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic [3:0]  dec_func;
    logic [4:0]  dec_rd;
    logic        dec_illegal;
    logic        load;

    assign opcode  = instr_i[6:0];
    assign funct3  = instr_i[14:12];
    assign alt     = instr_i[30];
    assign rs1_idx = instr_i[19:15];
    assign rs2_idx = instr_i[24:20];
    assign rd_idx  = instr_i[11:7];
    assign imm_i   = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u   = {instr_i[31:12], 12'b0};

    // x0 reads as zero even if a bypass source claims to write it.
    function automatic logic [31:0] pick_operand(input logic [4:0]  idx,
                                                 input logic [31:0] rf_data);
        logic [31:0] val;
        if (idx == 5'd0)
            val = 32'd0;
        else if (FWD_EN && ex_fwd_we_i && (ex_fwd_rd_i == idx))
            val = ex_fwd_data_i;
        else if (FWD_EN && wb_fwd_we_i && (wb_fwd_rd_i == idx))
            val = wb_fwd_data_i;
        else
            val = rf_data;
        return val;
    endfunction

    // Shared funct3 map for OP and OP-IMM; sub is only reachable from OP.
    function automatic logic [3:0] arith_func(input logic [2:0] f3,
                                              input logic       sub_en,
                                              input logic       sra_en);
        logic [3:0] fn;
        case (f3)
            3'b000:  fn = sub_en ? FN_SUB : FN_ADD;
            3'b001:  fn = FN_SLL;
            3'b010:  fn = FN_SLT;
            3'b011:  fn = FN_SLTU;
            3'b100:  fn = FN_XOR;
            3'b101:  fn = sra_en ? FN_SRA : FN_SRL;
            3'b110:  fn = FN_OR;
            default: fn = FN_AND;
        endcase
        return fn;
    endfunction

    assign rs1_val = pick_operand(rs1_idx, rs1_data_i);
    assign rs2_val = pick_operand(rs2_idx, rs2_data_i);

    always_comb begin
        dec_src1    = 32'd0;
        dec_src2    = 32'd0;
        dec_func    = FN_PASS;
        dec_rd      = 5'd0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_src1 = rs1_val;
                dec_src2 = rs2_val;
                dec_func = arith_func(funct3, alt, alt);
                dec_rd   = rd_idx;
            end
            OPC_OP_IMM: begin
                dec_src1 = rs1_val;
                dec_src2 = imm_i;
                dec_func = arith_func(funct3, 1'b0, alt);
                dec_rd   = rd_idx;
            end
            OPC_LUI: begin
                dec_src2 = imm_u;
                dec_func = FN_ADD;
                dec_rd   = rd_idx;
            end
            OPC_AUIPC: begin
                dec_src1 = pc_i;
                dec_src2 = imm_u;
                dec_func = FN_ADD;
                dec_rd   = rd_idx;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link address pc+4; target is computed elsewhere.
                dec_src1 = pc_i;
                dec_func = FN_LINK;
                dec_rd   = rd_idx;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_func = FN_EQ;
                    3'b001:  dec_func = FN_NE;
                    3'b100:  dec_func = FN_SLT;
                    3'b101:  dec_func = FN_GE;
                    3'b110:  dec_func = FN_SLTU;
                    3'b111:  dec_func = FN_GEU;
                    default: dec_illegal = 1'b1;
                endcase
                if (!dec_illegal) begin
                    dec_src1 = rs1_val;
                    dec_src2 = rs2_val;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign ready_o = !valid_o || ready_i;
    assign load    = valid_i && ready_o;

    // Flush wins over load; on drain or flush only the valid/illegal flags move,
    // the operand registers keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o   <= 1'b0;
            src1_o    <= 32'd0;
            src2_o    <= 32'd0;
            func_o    <= FN_PASS;
            rd_o      <= 5'd0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (load) begin
            valid_o   <= 1'b1;
            src1_o    <= dec_src1;
            src2_o    <= dec_src2;
            func_o    <= dec_func;
            rd_o      <= dec_rd;
            illegal_o <= dec_illegal;
        end else if (ready_i) begin
            valid_o   <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the execute ALU.
- Decodes the instruction word, selects and forwards operands, and generates the 4-bit ALU function code.
- Registers src1/src2/func into a one-deep ID/EX pipeline register with a valid/ready handshake and flush.
- The ALU consumes src1_o/src2_o/func_o combinationally in the following cycle.

Parameters:
- FWD_EN, 1, 1 = EX/MEM and MEM/WB bypass enabled; 0 = register-file data always used.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- valid_i  input  1  instruction/pc/rs data valid this cycle
- ready_o  output  1  stage can accept (combinational)
- instr_i  input  32  instruction word
- pc_i  input  32  instruction address
- rs1_data_i  input  32  register file read port 1
- rs2_data_i  input  32  register file read port 2
- ex_fwd_we_i  input  1  EX/MEM result will write rd
- ex_fwd_rd_i  input  5  EX/MEM destination
- ex_fwd_data_i  input  32  EX/MEM result
- wb_fwd_we_i  input  1  MEM/WB write enable
- wb_fwd_rd_i  input  5  MEM/WB destination
- wb_fwd_data_i  input  32  MEM/WB result
- flush_i  input  1  kill the registered instruction
- ready_i  input  1  ALU/EX stage accepts this cycle
- valid_o  output  1  registered operands valid
- src1_o  output  32  ALU operand 1
- src2_o  output  32  ALU operand 2
- func_o  output  4  ALU function code
- rd_o  output  5  destination register (0 for branches)
- illegal_o  output  1  unsupported opcode/funct3 (registered with instruction)

Behaviour:
- Reset (asynchronous): valid_o=0, src1_o=0, src2_o=0, func_o=4'hF, rd_o=0, illegal_o=0.
- Function code: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sltu, 6 slt, 7 sll, 8 srl, 9 sra, A eq, B ne, C geu, D ge, E src1+4, F pass src1.
- Immediates:
  - I-type: sign-extended instr[31:20].
  - U-type: {instr[31:12], 12'b0}.
- Opcode decode:
  - OP 0110011: src1=rs1, src2=rs2; funct3 000 → add, or sub when instr[30]=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when instr[30]=1; 110 or; 111 and.
  - OP-IMM 0010011: src1=rs1, src2=imm_I; same mapping, except 000 is always add and 101 selects sra by instr[30].
  - LUI: src1=0, src2=imm_U, add.
  - AUIPC: src1=pc_i, src2=imm_U, add.
  - JAL/JALR: src1=pc_i, src2=0, func E (link value).
  - BRANCH 1100011: src1=rs1, src2=rs2, rd_o=0; 000 A, 001 B, 100 6, 101 D, 110 5, 111 C; 010/011 illegal.
  - Any other opcode or illegal funct3: illegal_o=1, func F, src1=src2=0, rd_o=0.
- Operand selection, per source rsN = instr[19:15] / instr[24:20]:
  - rsN==0 → 0.
  - Else if FWD_EN && ex_fwd_we_i && ex_fwd_rd_i==rsN → ex_fwd_data_i. EX has priority over WB.
  - Else if FWD_EN && wb_fwd_we_i && wb_fwd_rd_i==rsN → wb_fwd_data_i.
  - Else rsN_data_i.
- Handshake:
  - ready_o = !valid_o || ready_i.
  - Load occurs when valid_i && ready_o. All registered outputs update on the clock edge and valid_o←1 (latency 1 cycle).
  - If ready_i && valid_o and no load: valid_o←0; data registers hold.
  - If !ready_i && valid_o: all outputs hold (stall). Upstream must hold its inputs.
- Flush: flush_i has priority over load. Next edge valid_o←0, illegal_o←0, and any valid_i that cycle is dropped. ready_o is unaffected by flush_i.
- Reset mid-stall clears valid_o immediately (asynchronous). No instruction is replayed.
- Arithmetic: PC add and immediate extension are 32-bit, wrap modulo 2^32. No other arithmetic is done in this block.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, no forward, ready_i=1 → next cycle valid_o=1, src1=5, src2=7, func=0, rd=3.
- addi x1,x0,-1 with rs1_data_i=0x1234 → src1=0 (x0 forced), src2=0xFFFFFFFF, func=0; srai x5,x5,3 (0x4032D293) → src2=0x403, func=9.
- Forwarding on rs1=x4: ex(we,rd=4,0xAA) and wb(we,rd=4,0xBB) → src1=0xAA; ex_we=0 → 0xBB; FWD_EN=0 → rs1_data_i.
- bgeu (funct3 111) → func C, rd_o=0; funct3 010 → illegal_o=1, func F. jal at pc=0x100 → src1=0x100, src2=0, func E.
- Stall: valid_o=1, ready_i=0 for 3 cycles while valid_i=1 → ready_o=0, outputs stable; ready_i=1 → new instruction loaded next edge.
- flush_i with valid_i=1 → valid_o=0 next cycle; assert reset while valid_o=1 → valid_o=0, func_o=F immediately without a clock.
